// File: rtl/memoria_ram_param.sv
// Parametrised SAP RAM: hardware clear after reset, debounced front-panel programming, run-mode bus writes.
// Latency: combinational read, single-edge write; button write lands DEB_CYCLES+2 edges after a clean press.
// No backpressure: writes during the clear sequence are dropped and busy flags the window.
module memoria_ram_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              programm_run,
    input  logic              WR_BUTTON,
    input  logic [DATA_W-1:0] ram_dip,
    input  logic [ADDR_W-1:0] in_mar,
    input  logic              RAM_IN,
    input  logic              RAM_OUT,
    input  logic [DATA_W-1:0] bus_in,
    output wire  [DATA_W-1:0] bus_out,
    output logic              busy,
    output logic              prog_ack
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DEB_CYCLES);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              btn_s1;
    logic              btn_s2;
    logic              deb;
    logic              deb_d;
    logic [CNT_W-1:0]  deb_cnt;
    logic              wr_pulse;
    logic              prog_we;
    logic              run_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CLEAR;
            clr_addr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_addr == ADDR_W'(DEPTH - 1)) begin
            state_d = IDLE;
        end
    end

    assign busy = (state_q == CLEAR);

    // Debouncer keeps running in every mode so a run-mode press cannot fire later.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_s1 <= WR_BUTTON;
            btn_s2 <= btn_s1;
            deb_d  <= deb;
            if (btn_s2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb     <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    assign wr_pulse = deb & ~deb_d;
    assign prog_we  = wr_pulse & (state_q == IDLE) & ~programm_run;
    assign run_we   = RAM_IN & (state_q == IDLE) & programm_run;

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (prog_we) begin
                mem[in_mar] <= ram_dip;
            end else if (run_we) begin
                mem[in_mar] <= bus_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prog_ack <= 1'b0;
        end else begin
            prog_ack <= prog_we;
        end
    end

    assign bus_out = (RAM_OUT && state_q == IDLE) ? mem[in_mar] : {DATA_W{1'bz}};

endmodule

// File: doc/memoria_ram_param.md
Name: memoria_ram_param

Overview:
Parametrised successor to the SAP-1 16x8 RAM, with configurable data width and address width. It has a synchronous single-clock write path and a hardware clear sequence after reset. It also has an on-chip synchroniser and debouncer for the manual write button, so front-panel programming no longer clocks the array from a raw button edge. It sits on the shared SAP bus, is addressed by the MAR, and is programmed from the DIP switches while the CPU is halted.

Parameters:
DATA_W, 8, word width in bits (bus, DIP switches, memory word)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (derived, not overridable)
DEB_CYCLES, 4, consecutive stable cycles needed to accept a button level change (>=2)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
programm_run  input  1  1 = CPU running (bus writes); 0 = programming mode (DIP writes)
WR_BUTTON  input  1  raw, asynchronous, bouncing manual write button
ram_dip  input  DATA_W  DIP-switch data for programming writes
in_mar  input  ADDR_W  address from the MAR, used for both reads and writes
RAM_IN  input  1  run-mode write strobe
RAM_OUT  input  1  bus output enable
bus_in  input  DATA_W  data from the bus
bus_out  output  DATA_W  tri-state drive onto the bus
busy  output  1  high while the clear sequence runs
prog_ack  output  1  one-cycle pulse after each accepted programming write

Behaviour:
- Reset (while high at an edge): state<=CLEAR, clr_addr<=0, sync FFs/deb level/deb counter/prog_ack<=0, busy=1, no memory writes. Memory contents are undefined until the clear completes.
- Main FSM state CLEAR:
  - Each edge with reset low writes 0 to mem[clr_addr] and increments clr_addr.
  - The edge that writes mem[DEPTH-1] moves state to IDLE.
  - busy is combinational (state==CLEAR), so it stays high for exactly DEPTH cycles after reset release.
- Reset asserted mid-clear restarts the sequence at address 0.
- During CLEAR:
  - RAM_IN and button writes are discarded; button edges that complete during CLEAR are lost.
  - bus_out = Z regardless of RAM_OUT.
- Main FSM state IDLE: stays there until reset.
- Button path:
  - WR_BUTTON goes through two sync FFs (s1, s2).
  - Debouncer, evaluated each edge: if s2==deb, cnt<=0; else if cnt==DEB_CYCLES-1, deb<=s2 and cnt<=0; else cnt<=cnt+1.
  - Pulses shorter than DEB_CYCLES cycles (after sync) never change deb.
  - deb_d is deb delayed by one edge; wr_pulse = deb & ~deb_d.
- Program write:
  - At an edge where wr_pulse=1, state=IDLE and programm_run=0: mem[in_mar]<=ram_dip, using values sampled at that edge.
  - prog_ack is registered high for the following cycle only.
  - Timing: E0 = first edge sampling WR_BUTTON=1 (clean press). deb rises at E(DEB_CYCLES+1). The write occurs at E(DEB_CYCLES+2); DEB_CYCLES=4 gives a write at E6 and prog_ack high from E6 to E7.
  - Release generates no write.
  - Holding the button produces one write only.
- Run write: at any edge with state=IDLE, programm_run=1 and RAM_IN=1, mem[in_mar]<=bus_in. Each cycle RAM_IN is high performs one write.
- Mode gating:
  - RAM_IN is ignored when programm_run=0.
  - wr_pulse is ignored when programm_run=1. The debouncer keeps tracking, so a press made in run mode does not fire later in programming mode.
  - programm_run is evaluated at the write edge itself.
- Read:
  - Combinational: bus_out = (RAM_OUT && state==IDLE) ? mem[in_mar] : all-Z.
  - With RAM_OUT and RAM_IN high in the same cycle, bus_out shows the old word; the new word is visible after the edge.
- Address wrap is inherent (ADDR_W bits index all DEPTH words). There is no out-of-range case.

Test Plan:
- Clear: fill via run writes (mem[i]=i+1, DATA_W=8, ADDR_W=4), pulse reset 1 cycle → busy high exactly 16 cycles; then RAM_OUT=1 reads 0x00 at all 16 addresses, and bus_out is Z while busy=1.
- Reset mid-clear: assert reset at clear cycle 7 for 1 cycle → busy stays high 16 more cycles after release, all words read 0.
- Debounced program: programm_run=0, in_mar=0x3, ram_dip=0xA5, WR_BUTTON high 20 cycles with 1–3-cycle bounces at start → exactly one write: mem[3]=0xA5 and a single prog_ack pulse. A lone 3-cycle glitch (DEB_CYCLES=4) → no write, no prog_ack.
- Run write/read: programm_run=1, RAM_IN=1 one cycle, in_mar=0xF, bus_in=0x3C → the next cycle with RAM_OUT=1 reads 0x3C. With RAM_OUT=0, bus_out=Z.
- Mode gating: programm_run=1 with a clean button press → no write, no prog_ack. programm_run=0 with RAM_IN=1 and bus_in=0xFF → memory unchanged.
- Same-cycle RAM_IN+RAM_OUT on mem[5]=0x11 with bus_in=0x22 → bus_out reads 0x11 that cycle and 0x22 the next.
